// File: rtl/bram_result_reader_pkg.sv
// bram_result_reader_pkg: FSM state encoding and row/lane geometry shared by the reader and its unpacker.
package bram_result_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPT,
        SEND,
        DONE
    } state_t;

    localparam int LANES  = 4;
    localparam int LANE_W = $clog2(LANES);

endpackage

// File: rtl/row_unpacker.sv
// row_unpacker: holds one BRAM row and streams it out MSB lane first over a valid/ready handshake.
module row_unpacker
    import bram_result_reader_pkg::*;
#(
    parameter int DWIDTH    = 64,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [DWIDTH-1:0]    row,
    input  logic                 send,
    input  logic                 last_row,
    input  logic                 m_ready,
    output logic                 m_valid,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last,
    output logic                 row_done
);

    logic [DWIDTH-1:0] row_buf;
    logic [LANE_W-1:0] lane;
    logic              last_lane;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_buf <= '0;
            lane    <= '0;
        end else if (load) begin
            row_buf <= row;
            lane    <= '0;
        end else if (m_valid && m_ready) begin
            lane    <= lane + LANE_W'(1);
        end
    end

    // lane 0 sits in the top bits of the row
    assign last_lane = lane == LANE_W'(LANES - 1);
    assign m_valid   = send;
    assign m_data    = row_buf[DWIDTH - 1 - int'(lane) * OUT_WIDTH -: OUT_WIDTH];
    assign m_last    = send && last_row && last_lane;
    assign row_done  = send && m_ready && last_lane;

endmodule

// File: rtl/bram_result_reader.sv
// bram_result_reader: reads run_count rows from BRAM1 one at a time and streams each row as four result words.
module bram_result_reader
    import bram_result_reader_pkg::*;
#(
    parameter int CNT_BIT   = 31,
    parameter int DWIDTH    = 64,
    parameter int AWIDTH    = 8,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_run_i,
    input  logic [CNT_BIT-1:0]   run_count_i,
    input  logic [DWIDTH-1:0]    q_b1_i,
    output logic [AWIDTH-1:0]    addr_b1_o,
    output logic                 ce_b1_o,
    output logic                 we_b1_o,
    output logic [DWIDTH-1:0]    d_b1_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [OUT_WIDTH-1:0] m_data_o,
    output logic                 m_last_o,
    output logic                 idle_o,
    output logic                 run_o,
    output logic                 done_o
);

    state_t             state, state_nx;
    logic [CNT_BIT-1:0] run_count, row_cnt;
    logic               row_done, last_row;

    assign last_row = row_cnt + CNT_BIT'(1) == run_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_count <= '0;
            row_cnt   <= '0;
        end else if (state == IDLE && start_run_i) begin
            run_count <= run_count_i;
            row_cnt   <= '0;
        end else if (row_done) begin
            row_cnt   <= row_cnt + CNT_BIT'(1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !start_run_i ? IDLE : (run_count_i == '0 ? DONE : REQ);
            REQ:     state_nx = CAPT;
            CAPT:    state_nx = SEND;
            SEND:    state_nx = !row_done ? SEND : (last_row ? DONE : REQ);
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ce_b1_o = state == REQ;
        idle_o  = state == IDLE;
        run_o   = state == REQ || state == CAPT || state == SEND;
        done_o  = state == DONE;
    end

    // the address is the low bits of the row counter, so it wraps while the count keeps going
    assign addr_b1_o = ce_b1_o ? row_cnt[AWIDTH-1:0] : '0;
    assign we_b1_o   = 1'b0;
    assign d_b1_o    = '0;

    row_unpacker #(
        .DWIDTH   (DWIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_row_unpacker (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (state == CAPT),
        .row     (q_b1_i),
        .send    (state == SEND),
        .last_row(last_row),
        .m_ready (m_ready_i),
        .m_valid (m_valid_o),
        .m_data  (m_data_o),
        .m_last  (m_last_o),
        .row_done(row_done)
    );

endmodule

// File: tb/tb_bram_result_reader.sv
// tb_bram_result_reader: table-driven and randomized runs checked against a row-list model of the expected stream.
module tb_bram_result_reader;

    localparam int CNT_BIT = 31, DWIDTH = 64, AWIDTH = 8, OUT_WIDTH = 16;

    logic                 clk = 0;
    logic                 reset_n = 1;
    logic                 start_run_i = 0;
    logic [CNT_BIT-1:0]   run_count_i = '0;
    logic [DWIDTH-1:0]    q_b1_i = '0;
    logic [AWIDTH-1:0]    addr_b1_o;
    logic                 ce_b1_o, we_b1_o;
    logic [DWIDTH-1:0]    d_b1_o;
    logic                 m_valid_o, m_last_o;
    logic                 m_ready_i = 0;
    logic [OUT_WIDTH-1:0] m_data_o;
    logic                 idle_o, run_o, done_o;

    typedef struct {
        int cnt;
        int mode;
        bit poke;
        int ew;
        int el;
    } vec_t;
    vec_t vecs[10];

    logic [DWIDTH-1:0]    mem [256];
    logic [OUT_WIDTH-1:0] exp_data[$];
    bit                   exp_last[$];
    int                   exp_addr[$];
    int checks = 0, errors = 0, cyc = 0, rmode = 0;
    int words = 0, lasts = 0, ces = 0, first_v = -1, done_cyc = -1;
    logic stalled = 0;
    logic [OUT_WIDTH-1:0] held = '0;

    bram_result_reader #(
        .CNT_BIT(CNT_BIT), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start_run_i(start_run_i), .run_count_i(run_count_i),
        .q_b1_i(q_b1_i), .addr_b1_o(addr_b1_o), .ce_b1_o(ce_b1_o), .we_b1_o(we_b1_o),
        .d_b1_o(d_b1_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
        .m_last_o(m_last_o), .idle_o(idle_o), .run_o(run_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // BRAM1 with one cycle read latency
    always @(posedge clk) if (ce_b1_o) q_b1_i <= mem[addr_b1_o];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic extra(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=unexpected required=none", name);
    endtask

    initial forever begin
        @(posedge clk);
        #1 m_ready_i = rmode == 0 ? 1'b1 : rmode == 1 ? ~m_ready_i : 1'($urandom % 2);
    end

    always @(negedge clk) begin
        cyc++;
        check("we_b1", we_b1_o, 0);
        check("d_b1", d_b1_o, 0);
        if (done_o) done_cyc = cyc;
        if (ce_b1_o) begin
            ces++;
            if (exp_addr.size() == 0) extra("extra_req");
            else check("addr", addr_b1_o, exp_addr.pop_front());
        end
        if (m_valid_o) begin
            if (first_v < 0) first_v = cyc;
            if (stalled) check("stall_data", m_data_o, held);
            if (m_ready_i) begin
                words++;
                if (m_last_o) lasts++;
                if (exp_data.size() == 0) extra("extra_word");
                else begin
                    check("data", m_data_o, exp_data.pop_front());
                    check("last", m_last_o, exp_last.pop_front());
                end
                stalled = 0;
            end else begin
                held = m_data_o;
                stalled = 1;
            end
        end else begin
            if (stalled && reset_n) check("stall_valid", m_valid_o, 1);
            stalled = 0;
        end
    end

    // expected stream: every row in order, four lanes each, top lane first
    task automatic build(input int cnt);
        logic [DWIDTH-1:0] r;
        exp_data.delete(); exp_last.delete(); exp_addr.delete();
        words = 0; lasts = 0; ces = 0; first_v = -1; done_cyc = -1;
        for (int i = 0; i < cnt; i++) begin
            exp_addr.push_back(i % 256);
            r = mem[i % 256];
            for (int l = 0; l < 4; l++) begin
                exp_data.push_back(r[DWIDTH - 1 - l * OUT_WIDTH -: OUT_WIDTH]);
                exp_last.push_back(i == cnt - 1 && l == 3);
            end
        end
    endtask

    task automatic start(input int cnt, output int t0);
        @(posedge clk);
        #1 start_run_i = 1; run_count_i = CNT_BIT'(cnt);
        @(posedge clk);
        #1 start_run_i = 0; run_count_i = CNT_BIT'($urandom);
        t0 = cyc + 1;
    endtask

    task automatic run_case(input vec_t v);
        int t0, budget;
        bit poked;
        rmode = v.mode;
        build(v.cnt);
        start(v.cnt, t0);
        budget = 40 * v.cnt + 20;
        poked = 0;
        do begin
            @(negedge clk);
            budget--;
            if (v.poke && !poked && m_valid_o) begin
                poked = 1;
                @(posedge clk);
                #1 start_run_i = 1; run_count_i = 5;
                @(posedge clk);
                #1 start_run_i = 0;
            end
        end while (!done_o && budget > 0);
        check("done_seen", done_o, 1);
        @(negedge clk);
        check("done_one_cycle", done_o, 0);
        check("back_idle", idle_o, 1);
        if (v.mode == 0 && !v.poke) begin
            check("done_time", done_cyc, t0 + 6 * v.cnt);
            if (v.cnt > 0) check("first_valid", first_v, t0 + 2);
        end
        check("words", words, v.ew);
        check("lasts", lasts, v.el);
        check("reqs", ces, v.cnt);
        check("addr_left", exp_addr.size(), 0);
        check("data_left", exp_data.size(), 0);
    endtask

    initial begin
        int t0, n;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        mem[0] = 64'h0001_0002_0003_0004;
        vecs[0] = '{1, 0, 0, 4, 1};
        vecs[1] = '{0, 0, 0, 0, 0};
        vecs[2] = '{3, 1, 0, 12, 1};
        vecs[3] = '{258, 0, 0, 1032, 1};
        vecs[4] = '{2, 0, 1, 8, 1};
        vecs[5] = '{4, 2, 0, 16, 1};
        for (int i = 6; i < 10; i++) begin
            n = $urandom_range(1, 6);
            vecs[i] = '{n, $urandom_range(0, 2), 0, n * 4, 1};
        end

        #2 reset_n = 0;
        #1;
        check("rst_idle", idle_o, 1);
        check("rst_run", run_o, 0);
        check("rst_done", done_o, 0);
        check("rst_ce", ce_b1_o, 0);
        check("rst_addr", addr_b1_o, 0);
        check("rst_valid", m_valid_o, 0);
        check("rst_data", m_data_o, 0);
        check("rst_last", m_last_o, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1;

        for (int i = 0; i < 10; i++) run_case(vecs[i]);

        // reset while row 1 is being sent
        rmode = 0;
        build(3);
        start(3, t0);
        n = 100;
        while (!(ces == 2 && m_valid_o) && n > 0) begin
            @(negedge clk);
            n--;
        end
        check("reach_row1", m_valid_o, 1);
        @(posedge clk);
        #1 reset_n = 0;
        #1;
        check("mid_rst_idle", idle_o, 1);
        check("mid_rst_valid", m_valid_o, 0);
        check("mid_rst_run", run_o, 0);
        @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1;
        repeat (3) @(negedge clk);
        check("no_resume_idle", idle_o, 1);
        check("no_resume_ce", ces, 2);
        run_case('{1, 0, 0, 4, 1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
